// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data RAM responder with valid/ready handshake and wait states
// Define DMEM_ERR_EN to flag misaligned and out-of-window accesses through rsp_err.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          r_write;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          do_access;
   logic          acc_write;
   logic          acc_err;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [AW-1:0] acc_idx;

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign rsp_valid = (state == S_RESP);

   // With zero wait states the access happens on the accept edge, so it must use the live request.
   assign do_access = reset && (((state == S_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                                ((state == S_WAIT) && (cnt == 4'd0)));
   assign acc_write = (state == S_IDLE) ? req_write : r_write;
   assign acc_addr  = (state == S_IDLE) ? req_addr  : r_addr;
   assign acc_wdata = (state == S_IDLE) ? req_wdata : r_wdata;
   assign acc_idx   = AW'((acc_addr - BASE_ADDR) >> 2);

`ifdef DMEM_ERR_EN
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                    ({1'b0, acc_addr} >= END_ADDR);
`else
   assign acc_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         r_write   <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write <= req_write;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  if (WAIT_STATES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_RESP;
               else             cnt   <= cnt - 4'd1;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
         // Only reachable from IDLE or WAIT, so never collides with the RESP clear above.
         if (do_access) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_access && acc_write && !acc_err) mem[acc_idx] <= acc_wdata;
   end

endmodule
